// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - funct codes that decode turns into start_mult / start_div
//   - HiLo read-select encodings (mfhi / mflo)
//   - FSM state and datapath mode encodings
package hilo_muldiv_unit_pkg;

  localparam logic [5:0] FUNCT_MULT = 6'b011000;
  localparam logic [5:0] FUNCT_DIV  = 6'b011010;

  localparam logic [1:0] HILO_HI = 2'b10;
  localparam logic [1:0] HILO_LO = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIX  = 2'b11
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

endpackage

// File: rtl/hilo_iter_core.sv
// Iterative unsigned datapath shared by multiply and divide.
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture operands, mode and clear the step counter
//   step      : perform one iteration
//   mode      : MODE_MUL (shift-add) or MODE_DIV (restoring division)
//   load_lo   : low half of accumulator (multiplier / dividend magnitude)
//   load_m    : multiplicand / divisor magnitude
//   acc_hi/lo : mul -> {product hi, product lo}; div -> {remainder, quotient}
//   last      : the step in progress is the final one
module hilo_iter_core
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] load_lo,
  input  logic [WIDTH-1:0] load_m,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);

  localparam int unsigned CW = $clog2(ITER) + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   m;
  mode_t              mode_q;
  logic [CW-1:0]      cnt;

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole pair right
    // keeping the carry.
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    // Divide: shift the next dividend bit into the partial remainder and
    // trial-subtract; a set MSB of the difference means "restore".
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = rem_sh - {1'b0, m};
    if (mode_q == MODE_MUL) begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end else if (diff[WIDTH]) begin
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      m      <= '0;
      mode_q <= MODE_MUL;
      cnt    <= '0;
    end else if (load) begin
      acc    <= {{WIDTH{1'b0}}, load_lo};
      m      <= load_m;
      mode_q <= mode;
      cnt    <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      cnt <= cnt + 1'b1;
    end
  end

  assign acc_hi = acc[2*WIDTH-1:WIDTH];
  assign acc_lo = acc[WIDTH-1:0];
  assign last   = (cnt == CW'(ITER - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative signed multiply/divide unit with architectural HI/LO registers.
//   CLK, RESET           : clock, synchronous active-high reset
//   start_mult/start_div : EX holds a valid mult / div (mult wins if both)
//   rs_data, rt_data     : operands, sampled only when the op is accepted
//   HiLo                 : 10 read HI, 01 read LO, otherwise read 0
//   HiLo_out             : combinational read of HI/LO
//   Busy                 : operation in flight
//   Stall                : hold IF/ID/EX while busy and EX needs the unit
//   Done                 : one-cycle pulse when HI/LO are written
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [1:0]       HiLo,
  output logic [WIDTH-1:0] HiLo_out,
  output logic             Busy,
  output logic             Stall,
  output logic             Done
);

  state_t           state;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] dividend;
  logic             neg_a;     // product sign / quotient sign
  logic             neg_r;     // remainder sign (dividend sign)
  logic             dvz;
  logic             op_div;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             accept_mul, accept_div;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic             core_last;

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  always_comb begin
    rs_mag     = rs_data[WIDTH-1] ? -rs_data : rs_data;
    rt_mag     = rt_data[WIDTH-1] ? -rt_data : rt_data;
    accept_mul = (state == ST_IDLE) && start_mult;
    accept_div = (state == ST_IDLE) && !start_mult && start_div;
  end

  hilo_iter_core #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_core (
    .clk     (CLK),
    .rst     (RESET),
    .load    (accept_mul | accept_div),
    .step    ((state == ST_MUL) || (state == ST_DIV)),
    .mode    (accept_div ? MODE_DIV : MODE_MUL),
    .load_lo (accept_div ? rs_mag : rt_mag),
    .load_m  (accept_div ? rt_mag : rs_mag),
    .acc_hi  (core_hi),
    .acc_lo  (core_lo),
    .last    (core_last)
  );

  always_comb begin
    prod_s = neg_a ? -{core_hi, core_lo} : {core_hi, core_lo};
    quo_s  = neg_a ? -core_lo : core_lo;
    rem_s  = neg_r ? -core_hi : core_hi;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      dividend <= '0;
      neg_a    <= 1'b0;
      neg_r    <= 1'b0;
      dvz      <= 1'b0;
      op_div   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_mul || accept_div) begin
            state    <= accept_mul ? ST_MUL : ST_DIV;
            busy_q   <= 1'b1;
            op_div   <= accept_div;
            neg_a    <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
            neg_r    <= rs_data[WIDTH-1];
            dvz      <= (rt_data == '0);
            dividend <= rs_data;
          end
        end
        ST_MUL, ST_DIV: begin
          if (core_last) state <= ST_FIX;
        end
        ST_FIX: begin
          if (!op_div) begin
            {hi, lo} <= prod_s;
          end else if (dvz) begin
            hi <= dividend;
            lo <= '1;
          end else begin
            hi <= rem_s;
            lo <= quo_s;
          end
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (HiLo)
      HILO_HI: HiLo_out = hi;
      HILO_LO: HiLo_out = lo;
      default: HiLo_out = '0;
    endcase
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Stall = busy_q & (start_mult | start_div | (HiLo != 2'b00));

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [1:0]  HiLo = 2'b00;
  logic [31:0] HiLo_out;
  logic        Busy, Stall, Done;

  int vectors = 0;
  int errors  = 0;

  hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start_mult (start_mult),
    .start_div  (start_div),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .HiLo       (HiLo),
    .HiLo_out   (HiLo_out),
    .Busy       (Busy),
    .Stall      (Stall),
    .Done       (Done)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic read_hilo(input logic [1:0] sel, output logic [31:0] v);
    HiLo = sel;
    #1;
    v = HiLo_out;
  endtask

  // Presents one op in IDLE, scrambles the operands after accept, optionally
  // holds HiLo and injects a one-cycle start_div at accept+inj. Returns the
  // number of edges from accept to Done (0 on timeout).
  task automatic run_op(input bit is_mul, input bit both, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] hl, input int inj,
                        output int lat, output int busy_cnt, output int stall_cnt,
                        output bit stall0, output bit inj_stall);
    start_mult = is_mul | both;
    start_div  = !is_mul | both;
    rs_data    = a;
    rt_data    = b;
    #1;
    stall0 = Stall;
    tick();
    start_mult = 1'b0;
    start_div  = 1'b0;
    rs_data    = ~a;
    rt_data    = b + 32'd1;
    HiLo       = hl;
    #1;
    busy_cnt  = Busy;
    stall_cnt = Stall;
    lat       = 0;
    inj_stall = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      start_div = 1'b0;
      if (Done) begin
        lat = i;
        break;
      end
      if (i == inj) start_div = 1'b1;
      #1;
      busy_cnt  += Busy;
      stall_cnt += Stall;
      if (i == inj) inj_stall = Stall;
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    HiLo  = 2'b10;
    #1;
    vectors++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", Busy); end
    vectors++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", Done); end
    vectors++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", Stall); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", v); end
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", v); end
    HiLo = 2'b00;
  endtask

  task automatic test_mult_basic;
    int lat, bc, sc; bit s0, is; logic [31:0] v;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, 2'b00, -1, lat, bc, sc, s0, is);
    vectors++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d want 33", lat); end
    vectors++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
    vectors++; if (Busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done got %0b want 0", Busy); end
    vectors++; if (s0 !== 1'b0) begin errors++; $display("FAIL mult_idle_stall got %0b want 0", s0); end
    vectors++; if (sc !== 0) begin errors++; $display("FAIL mult_stall_cycles got %0d want 0", sc); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", v); end
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", v); end
    read_hilo(2'b11, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL read_sel11 got %h want 0", v); end
    HiLo = 2'b00;
    tick();
    vectors++; if (Done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %0b want 0", Done); end
  endtask

  task automatic test_div_stall;
    int lat, bc, sc; bit s0, is; logic [31:0] v;
    run_op(1'b0, 1'b0, 32'd100, 32'd7, 2'b01, -1, lat, bc, sc, s0, is);
    vectors++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", lat); end
    vectors++; if (sc !== 33) begin errors++; $display("FAIL div_stall_cycles got %0d want 33", sc); end
    vectors++; if (Stall !== 1'b0) begin errors++; $display("FAIL div_stall_at_done got %0b want 0", Stall); end
    vectors++; if (HiLo_out !== 32'd14) begin errors++; $display("FAIL div_mflo_at_done got %h want 0000000e", HiLo_out); end
    tick();
    vectors++; if (HiLo_out !== 32'd14) begin errors++; $display("FAIL div_mflo_after got %h want 0000000e", HiLo_out); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'd2) begin errors++; $display("FAIL div_hi got %h want 00000002", v); end
    HiLo = 2'b00;
  endtask

  task automatic test_div_signs;
    int lat, bc, sc; bit s0, is; logic [31:0] v;
    run_op(1'b0, 1'b0, 32'hFFFFFFF9, 32'd2, 2'b00, -1, lat, bc, sc, s0, is);
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'hFFFFFFFD) begin errors++; $display("FAIL divneg_lo got %h want fffffffd", v); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL divneg_hi got %h want ffffffff", v); end
    HiLo = 2'b00;
    run_op(1'b0, 1'b0, 32'd5, 32'd0, 2'b00, -1, lat, bc, sc, s0, is);
    vectors++; if (lat !== 33) begin errors++; $display("FAIL dvz_latency got %0d want 33", lat); end
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL dvz_lo got %h want ffffffff", v); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'd5) begin errors++; $display("FAIL dvz_hi got %h want 00000005", v); end
    HiLo = 2'b00;
  endtask

  task automatic test_corners;
    int lat, bc, sc; bit s0, is; logic [31:0] v;
    run_op(1'b0, 1'b0, 32'h80000000, 32'hFFFFFFFF, 2'b00, -1, lat, bc, sc, s0, is);
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'h80000000) begin errors++; $display("FAIL intmin_div_lo got %h want 80000000", v); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL intmin_div_hi got %h want 0", v); end
    HiLo = 2'b00;
    run_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 2'b00, -1, lat, bc, sc, s0, is);
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'h40000000) begin errors++; $display("FAIL intmin_mul_hi got %h want 40000000", v); end
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL intmin_mul_lo got %h want 0", v); end
    HiLo = 2'b00;
  endtask

  task automatic test_both_starts;
    int lat, bc, sc; bit s0, is; logic [31:0] v;
    run_op(1'b1, 1'b1, 32'd3, 32'd4, 2'b00, 5, lat, bc, sc, s0, is);
    vectors++; if (lat !== 33) begin errors++; $display("FAIL both_latency got %0d want 33", lat); end
    vectors++; if (is !== 1'b1) begin errors++; $display("FAIL busy_start_stall got %0b want 1", is); end
    vectors++; if (sc !== 1) begin errors++; $display("FAIL both_stall_cycles got %0d want 1", sc); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL both_hi got %h want 0", v); end
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'd12) begin errors++; $display("FAIL both_lo got %h want 0000000c", v); end
    HiLo = 2'b00;
    tick();
    tick();
    vectors++; if (Busy !== 1'b0) begin errors++; $display("FAIL dropped_div_busy got %0b want 0", Busy); end
  endtask

  task automatic test_reset_abort;
    int dones; logic [31:0] v;
    start_mult = 1'b1;
    rs_data    = 32'd9;
    rt_data    = 32'd9;
    tick();
    start_mult = 1'b0;
    repeat (9) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    vectors++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", Busy); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL abort_hi got %h want 0", v); end
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL abort_lo got %h want 0", v); end
    HiLo  = 2'b00;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      dones += Done;
    end
    vectors++; if (dones !== 0) begin errors++; $display("FAIL abort_done_pulses got %0d want 0", dones); end
  endtask

  task automatic test_back_to_back;
    int lat, bc, sc; bit s0, is; logic [31:0] v;
    run_op(1'b1, 1'b0, 32'd2, 32'd3, 2'b01, -1, lat, bc, sc, s0, is);
    vectors++; if (lat !== 33) begin errors++; $display("FAIL b2b_mul_latency got %0d want 33", lat); end
    vectors++; if (HiLo_out !== 32'd6) begin errors++; $display("FAIL b2b_mul_lo got %h want 00000006", HiLo_out); end
    run_op(1'b0, 1'b0, 32'hFFFFFFF0, 32'd3, 2'b00, -1, lat, bc, sc, s0, is);
    vectors++; if (s0 !== 1'b0) begin errors++; $display("FAIL b2b_accept_stall got %0b want 0", s0); end
    vectors++; if (lat !== 33) begin errors++; $display("FAIL b2b_div_latency got %0d want 33", lat); end
    read_hilo(2'b01, v);
    vectors++; if (v !== 32'hFFFFFFFB) begin errors++; $display("FAIL b2b_div_lo got %h want fffffffb", v); end
    read_hilo(2'b10, v);
    vectors++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_div_hi got %h want ffffffff", v); end
    HiLo = 2'b00;
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_div_stall();
    test_div_signs();
    test_corners();
    test_both_starts();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative signed multiply/divide unit with architectural HI/LO registers, in the EX stage directly downstream of the decode control unit.
- Consumes the decoded mult/div starts, derived from funct 011000 and 011010 (RegWrite=0), and the 2-bit HiLo field EX[1:0] (10 = mfhi, 01 = mflo).
- Returns the HI/LO read data and a stall request that holds IF/ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, datapath iterations (must equal WIDTH).

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- start_mult  in  1  EX holds a valid mult.
- start_div  in  1  EX holds a valid div.
- rs_data  in  WIDTH  operand A (multiplicand / dividend).
- rt_data  in  WIDTH  operand B (multiplier / divisor).
- HiLo  in  2  EX[1:0]: 10 read HI, 01 read LO, 00 none.
- HiLo_out  out  WIDTH  read data for mfhi/mflo.
- Busy  out  1  operation in flight.
- Stall  out  1  pipeline hold request.
- Done  out  1  one-cycle pulse when HI/LO are written.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (CLK, RESET).
  - RESET high at an edge: state=IDLE, HI=0, LO=0, counter=0, Busy=0, Done=0.
  - Reset mid-operation aborts; HI/LO end at 0, never partial.
- States: IDLE, MUL, DIV, FIX.
  - IDLE: start_mult sampled high goes to MUL; else start_div high goes to DIV.
    - Both high: mult wins, div is dropped.
    - On accept, latch |rs| and |rt| magnitudes, result signs (mult: sA^sB; div quotient sA^sB, remainder sA) and the raw dividend. Clear counter.
  - MUL: unsigned shift-add, one bit per cycle, 2*WIDTH product accumulator. After ITER cycles go to FIX.
  - DIV: unsigned restoring division, one quotient bit per cycle. After ITER cycles go to FIX.
  - FIX: apply sign correction, write HI/LO, pulse Done, go to IDLE.
- Latency: accept at edge k; HI/LO written at edge k+ITER+1 (k+33).
  - Busy is 1 from after edge k until edge k+33, where it drops as Done rises.
  - Done is high for exactly one cycle.
- Results:
  - mult: {HI,LO} = signed 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - Divide by zero: LO = all ones, HI = raw dividend, regardless of sign.
  - INT_MIN / -1: LO = 0x80000000, HI = 0 (wraps, no trap).
- Read path: HiLo_out is combinational from the registered HI/LO.
  - 10 gives HI, 01 gives LO, 00 or 11 gives 0.
  - After Done, reads return the new value.
- Stall = Busy & (start_mult | start_div | HiLo != 00).
  - Starts presented while Busy are ignored; the stalled pipeline re-presents them.
  - A start presented in IDLE is accepted that cycle with no stall.
  - A mfhi/mflo in the cycle after accept stalls.
- Operands are sampled only at accept; later changes to rs_data/rt_data have no effect.
- Back-to-back: a start in the cycle after Done is accepted normally.

Decomposition:
- Shared package: FUNCT_MULT=6'b011000, FUNCT_DIV=6'b011010, HILO_HI=2'b10, HILO_LO=2'b01, state encoding (IDLE/MUL/DIV/FIX).
- One sub-module: hilo_iter_core. It holds the shared shift register, accumulator/remainder and counter, with mode select and step enable.
- The top level holds the FSM, sign handling, HI/LO registers and the read mux.

Test Plan:
- Reset, then mult rs=7, rt=0xFFFFFFFD -> Busy for 33 cycles; Done at k+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- div rs=100, rt=7, then mflo held from k+1 -> Stall=1 until k+33; LO=14, HI=2; HiLo_out=14 the cycle after Done.
- div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then div 5/0 -> LO=0xFFFFFFFF, HI=5.
- div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Then mult 0x80000000 * 0x80000000 -> HI=0x40000000, LO=0.
- start_mult and start_div together (3, 4) -> mult runs: HI=0, LO=12. A start_div at k+5 while Busy -> Stall=1, no effect on the result.
- RESET at k+10 of a mult -> Busy=0, HI=LO=0, no Done pulse. A new mult 2*3 afterwards -> LO=6 at +33.
